// File: rtl/hs_mem_spram_asyncrd_be.sv
// hs_mem_spram_asyncrd_be
//   Single-port RAM with asynchronous (combinational) read, per-byte write
//   enables and a self-timed clear sweep that writes INIT_VALUE to every
//   physical location after reset or on request.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst_n      : asynchronous active-low reset (restarts the clear sweep)
//   addr       : shared read/write address
//   wdata      : write data
//   wen        : write enable
//   be         : byte enables, bit i covers wdata[8i+7:8i] (top lane may be partial)
//   clr_req    : single-cycle request to start a clear sweep (ignored while sweeping)
//   rdata      : combinational read data (INIT_VALUE while sweeping)
//   init_busy  : a clear sweep is in progress
//   wr_drop    : registered one-cycle pulse when a write was discarded during a sweep
module hs_mem_spram_asyncrd_be #(
  parameter int unsigned           DATA_WIDTH = 8,
  parameter int unsigned           DATA_DEPTH = 16,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  parameter bit                    WRITE_THRU = 1'b0,
  localparam int unsigned ADDR_WIDTH = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1,
  localparam int unsigned BE_WIDTH   = (DATA_WIDTH + 7) / 8,
  localparam int unsigned DEPTH_REAL = 1 << $clog2(DATA_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wen,
  input  logic [BE_WIDTH-1:0]   be,
  input  logic                  clr_req,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  init_busy,
  output logic                  wr_drop
);

  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(DEPTH_REAL - 1);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic                    wr_drop_q, wr_drop_d;

  logic [DATA_WIDTH-1:0]   ram_q [DEPTH_REAL];

  logic [DATA_WIDTH-1:0]   be_mask;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [DATA_WIDTH-1:0]   merged_word;
  logic                    wr_active;

  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  // Expand byte enables to a per-bit mask; the top lane covers only the
  // remaining bits when DATA_WIDTH is not a multiple of 8.
  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_mask
    assign be_mask[i] = be[i / 8];
  end

  assign rd_word     = ram_q[addr];
  assign merged_word = (rd_word & ~be_mask) | (wdata & be_mask);
  assign wr_active   = wen & (|be);

  // Storage write port: the sweep owns the port in INIT, the user in READY.
  // While rst_n is low the FSM sits in INIT with ptr=0, so location 0 keeps
  // being written with INIT_VALUE; it is the first address re-cleared by the
  // sweep that follows anyway.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = addr;
    mem_wdata = merged_word;
    if (state_q == ST_INIT) begin
      mem_we    = 1'b1;
      mem_addr  = ptr_q;
      mem_wdata = INIT_VALUE;
    end else begin
      mem_we    = wr_active;
    end
  end

  // No reset on the array itself.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      ram_q[mem_addr] <= mem_wdata;
    end
  end

  // Control FSM next-state logic.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    wr_drop_d = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        // clr_req is deliberately not looked at here: no restart, no extension.
        wr_drop_d = wr_active;
        if (ptr_q == PTR_LAST) begin
          state_d = ST_READY;
          ptr_d   = '0;
        end else begin
          ptr_d   = ptr_q + 1'b1;
        end
      end
      ST_READY: begin
        // Any write in this cycle goes through the storage port above first.
        if (clr_req) begin
          state_d = ST_INIT;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_INIT;
      ptr_q     <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  assign init_busy = (state_q == ST_INIT);
  assign wr_drop   = wr_drop_q;

  always_comb begin
    rdata = rd_word;
    if (state_q == ST_INIT) begin
      rdata = INIT_VALUE;
    end else if (WRITE_THRU && wen) begin
      // With be=0 the merged word equals the stored word, so wen alone suffices.
      rdata = merged_word;
    end
  end

endmodule

// File: tb/tb_hs_mem_spram_asyncrd_be.sv
// Testbench for hs_mem_spram_asyncrd_be (DATA_WIDTH=16, DATA_DEPTH=16 padded
// from 12, INIT_VALUE=16'hA5A5). Two instances share all inputs: one with
// old-data read-during-write, one with write-through.
module tb_hs_mem_spram_asyncrd_be;

  localparam logic [15:0] IV = 16'hA5A5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  addr = '0;
  logic [15:0] wdata = '0;
  logic        wen = 1'b0;
  logic [1:0]  be = '0;
  logic        clr_req = 1'b0;

  logic [15:0] rdata_o, rdata_n;
  logic        busy_o, busy_n, drop_o, drop_n;

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  hs_mem_spram_asyncrd_be #(
    .DATA_WIDTH(16), .DATA_DEPTH(12), .INIT_VALUE(16'hA5A5), .WRITE_THRU(1'b0)
  ) u_dut_old (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .wen(wen), .be(be),
    .clr_req(clr_req), .rdata(rdata_o), .init_busy(busy_o), .wr_drop(drop_o)
  );

  hs_mem_spram_asyncrd_be #(
    .DATA_WIDTH(16), .DATA_DEPTH(12), .INIT_VALUE(16'hA5A5), .WRITE_THRU(1'b1)
  ) u_dut_new (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .wen(wen), .be(be),
    .clr_req(clr_req), .rdata(rdata_n), .init_busy(busy_n), .wr_drop(drop_n)
  );

  // Reference model
  logic [15:0] m_ram [16];
  bit          m_init = 1'b1;
  int          m_ptr = 0;
  bit          m_drop = 1'b0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  // One clock cycle: drive at posedge+1, compare at negedge, advance model at posedge.
  task automatic step(input logic w, input logic [1:0] b, input logic [3:0] a,
                      input logic [15:0] d, input logic c, output logic busy_obs);
    logic [15:0] mask, base, merged;
    exp_t e;
    wen = w; be = b; addr = a; wdata = d; clr_req = c;
    mask   = {{8{b[1]}}, {8{b[0]}}};
    base   = m_ram[a];
    merged = (base & ~mask) | (d & mask);
    push("rdata_old", 32'(m_init ? IV : base));
    push("rdata_thru", 32'(m_init ? IV : (w ? merged : base)));
    push("busy_old", 32'(m_init));
    push("busy_thru", 32'(m_init));
    push("drop_old", 32'(m_drop));
    push("drop_thru", 32'(m_drop));
    @(negedge clk);
    e = sb.pop_front(); check(e.tag, 32'(rdata_o), e.exp);
    e = sb.pop_front(); check(e.tag, 32'(rdata_n), e.exp);
    e = sb.pop_front(); check(e.tag, 32'(busy_o), e.exp);
    e = sb.pop_front(); check(e.tag, 32'(busy_n), e.exp);
    e = sb.pop_front(); check(e.tag, 32'(drop_o), e.exp);
    e = sb.pop_front(); check(e.tag, 32'(drop_n), e.exp);
    busy_obs = busy_o;
    @(posedge clk);
    if (m_init) begin
      m_ram[m_ptr] = IV;
      m_drop = w && (b != 2'b00);
      if (m_ptr == 15) begin
        m_init = 1'b0;
        m_ptr  = 0;
      end else begin
        m_ptr++;
      end
    end else begin
      if (w) m_ram[a] = merged;
      m_drop = 1'b0;
      if (c) begin
        m_init = 1'b1;
        m_ptr  = 0;
      end
    end
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 with rst_n released.
  task automatic do_reset();
    wen = 1'b0; be = '0; clr_req = 1'b0;
    rst_n  = 1'b0;
    m_init = 1'b1; m_ptr = 0; m_drop = 1'b0;
    #2;
    check("rst_busy", 32'(busy_o), 32'd1);
    check("rst_drop", 32'(drop_o), 32'd0);
    check("rst_rdata_old", 32'(rdata_o), 32'(IV));
    check("rst_rdata_thru", 32'(rdata_n), 32'(IV));
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Runs cycles until init_busy drops, counting busy cycles (bounded).
  task automatic sweep(input int drop_k, input bit spam, input logic [3:0] rd_addr);
    int   cnt = 0;
    bit   done = 1'b0;
    logic bo;
    for (int k = 0; k < 40 && !done; k++) begin
      step(k == drop_k, (k == drop_k) ? 2'b11 : 2'b00, rd_addr, 16'h5555,
           spam && (k < 15) && k[0], bo);
      if (bo) cnt++;
      else done = 1'b1;
    end
    check("sweep_len", 32'(cnt), 32'd16);
  endtask

  initial begin
    logic bo;
    @(posedge clk); #1;

    // Reset and first sweep; every location reads INIT_VALUE afterwards.
    do_reset();
    sweep(-1, 1'b0, 4'd0);
    for (int unsigned i = 0; i < 16; i++) step(1'b0, 2'b00, 4'(i), 16'h0, 1'b0, bo);

    // Low-lane write, read-during-write on both variants, then read back.
    step(1'b1, 2'b01, 4'd3, 16'h1234, 1'b0, bo);
    step(1'b0, 2'b00, 4'd3, 16'h0, 1'b0, bo);
    check("ram3_const", 32'(rdata_o), 32'h0000A534);

    // wen with be=0: no change, no drop.
    step(1'b1, 2'b00, 4'd4, 16'hFFFF, 1'b0, bo);
    step(1'b0, 2'b00, 4'd4, 16'h0, 1'b0, bo);

    // High-lane and full writes, top address.
    step(1'b1, 2'b10, 4'd5, 16'hCAFE, 1'b0, bo);
    step(1'b1, 2'b11, 4'd15, 16'h0F0F, 1'b0, bo);
    step(1'b0, 2'b00, 4'd5, 16'h0, 1'b0, bo);
    step(1'b0, 2'b00, 4'd15, 16'h0, 1'b0, bo);

    // clr_req together with a write: write lands, then a full sweep with a
    // dropped write at cycle 5 and repeated clr_req pulses.
    step(1'b1, 2'b11, 4'd7, 16'hBEEF, 1'b1, bo);
    sweep(5, 1'b1, 4'd7);
    step(1'b0, 2'b00, 4'd7, 16'h0, 1'b0, bo);
    check("ram7_cleared", 32'(rdata_o), 32'h0000A5A5);
    step(1'b0, 2'b00, 4'd3, 16'h0, 1'b0, bo);

    // Reset in the middle of a sweep: full sweep follows.
    step(1'b1, 2'b11, 4'd9, 16'h7777, 1'b1, bo);
    for (int unsigned k = 0; k < 9; k++) step(1'b0, 2'b00, 4'd9, 16'h0, 1'b0, bo);
    do_reset();
    sweep(-1, 1'b0, 4'd9);
    step(1'b0, 2'b00, 4'd9, 16'h0, 1'b0, bo);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
